// File: rtl/sbd_digit_serializer.sv
// rtl/sbd_digit_serializer.sv - parallel-to-serial 2-bit digit feeder for the sqrt datapath
// Optional leading-zero normalisation: define SBD_SERIALIZER_NORM_EN
module sbd_digit_serializer #(
   parameter int bitlength = 48,
   parameter int cntwidth  = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [bitlength-1:0] PIN,
   input  logic                 LOAD,
   output logic                 BUSY,
   output logic [1:0]           DOUT,
   output logic                 DVALID,
   input  logic                 DREADY,
   output logic                 LAST,
   output logic [cntwidth-1:0]  SKIP
);

`ifdef SBD_SERIALIZER_NORM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, SEND = 2'd2} state_t;
   localparam state_t first_state = NORM;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_t;
   localparam state_t first_state = SEND;
`endif

   localparam logic [cntwidth-1:0] half = cntwidth'(bitlength / 2);
   localparam logic [cntwidth-1:0] one  = cntwidth'(1);

   state_t                state, nstate;
   logic [bitlength-1:0]  sreg;
   logic [cntwidth-1:0]   cnt;
   logic                  load_acc;
   logic                  xfer;
   logic                  norm_shift;
   logic                  top_zero;

   assign top_zero = (sreg[bitlength-1:bitlength-2] == 2'b00);
   assign load_acc = (state == IDLE) && LOAD;
   assign xfer     = (state == SEND) && DREADY;
`ifdef SBD_SERIALIZER_NORM_EN
   assign norm_shift = (state == NORM) && top_zero && (cnt > one);
`else
   assign norm_shift = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (LOAD) nstate = first_state;
`ifdef SBD_SERIALIZER_NORM_EN
         NORM: if (!(top_zero && (cnt > one))) nstate = SEND;
`endif
         SEND: if (DREADY && (cnt == one)) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Normalisation and transmission share the same left shift; LOAD wins only in IDLE.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load_acc) begin
         sreg <= PIN;
         cnt  <= half;
      end else if (xfer || norm_shift) begin
         sreg <= {sreg[bitlength-3:0], 2'b00};
         cnt  <= cnt - one;
      end
   end

`ifdef SBD_SERIALIZER_NORM_EN
   logic [cntwidth-1:0] skip_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)            skip_q <= '0;
      else if (load_acc)   skip_q <= '0;
      else if (norm_shift) skip_q <= skip_q + one;
   end
`endif

   always_comb begin
      BUSY   = (state != IDLE);
      DVALID = (state == SEND);
      LAST   = (state == SEND) && (cnt == one);
      DOUT   = sreg[bitlength-1:bitlength-2];
`ifdef SBD_SERIALIZER_NORM_EN
      SKIP   = skip_q;
`else
      SKIP   = '0;
`endif
   end

endmodule

// File: tb/tb_sbd_digit_serializer.sv
// tb/tb_sbd_digit_serializer.sv - directed vector bench for sbd_digit_serializer
// Expectations follow SBD_SERIALIZER_NORM_EN when defined
module tb_sbd_digit_serializer;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   logic [7:0]  pin8;
   logic        load8, dready8, busy8, dvalid8, last8;
   logic [1:0]  dout8;
   logic [2:0]  skip8;

   logic [47:0] pin48;
   logic        load48, dready48, busy48, dvalid48, last48;
   logic [1:0]  dout48;
   logic [5:0]  skip48;

   sbd_digit_serializer #(.bitlength(8), .cntwidth(3)) dut8 (
      .CLK(CLK), .RST(RST), .PIN(pin8), .LOAD(load8), .BUSY(busy8), .DOUT(dout8),
      .DVALID(dvalid8), .DREADY(dready8), .LAST(last8), .SKIP(skip8)
   );

   sbd_digit_serializer dut48 (
      .CLK(CLK), .RST(RST), .PIN(pin48), .LOAD(load48), .BUSY(busy48), .DOUT(dout48),
      .DVALID(dvalid48), .DREADY(dready48), .LAST(last48), .SKIP(skip48)
   );

   typedef struct {
      logic [7:0] pin;
      logic [7:0] dig;
      int         ndig;
      int         skip;
   } vec_t;

   vec_t tbl[6];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic int exp_lat(input int skip);
`ifdef SBD_SERIALIZER_NORM_EN
      return skip + 1;
`else
      return 0;
`endif
   endfunction

   task automatic wait_valid8(input string name, input int lat_exp);
      int lat;
      lat = 0;
      while (!dvalid8 && lat < 20) begin
         step();
         lat++;
      end
      chk(name, lat, lat_exp);
   endtask

   task automatic drain8(input logic [7:0] exp, input int ndig);
      logic [7:0] e;
      e = exp;
      dready8 = 1'b1;
      for (int i = 0; i < ndig; i++) begin
         chk("dvalid8", dvalid8, 1'b1);
         chk("dout8", dout8, e[7:6]);
         chk("last8", last8, (i == ndig - 1));
         e = {e[5:0], 2'b00};
         step();
      end
      chk("busy8 end", busy8, 1'b0);
      chk("dvalid8 end", dvalid8, 1'b0);
   endtask

   task automatic run48(input logic [47:0] w);
      logic [47:0] e;
      logic        lastflag;
      int          n, guard;
      e = w;
      pin48 = w;
      load48 = 1'b1;
      dready48 = 1'b1;
      step();
      load48 = 1'b0;
      chk("busy48 start", busy48, 1'b1);
      guard = 0;
      while (!dvalid48 && guard < 10) begin
         step();
         guard++;
      end
      chk("dvalid48 rise", dvalid48, 1'b1);
      n = 0;
      lastflag = 1'b0;
      while (!lastflag && dvalid48 && n < 60) begin
         chk("dout48", dout48, e[47:46]);
         chk("last48", last48, (n == 23));
         lastflag = last48;
         e = {e[45:0], 2'b00};
         n++;
         step();
      end
      chk("transfers48", n, 24);
      chk("busy48 end", busy48, 1'b0);
      chk("skip48", skip48, 6'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
`ifdef SBD_SERIALIZER_NORM_EN
      tbl[0] = '{8'hB4, 8'hB4, 4, 0};
      tbl[1] = '{8'h0D, 8'hD0, 2, 2};
      tbl[2] = '{8'h00, 8'h00, 1, 3};
      tbl[3] = '{8'hFF, 8'hFF, 4, 0};
      tbl[4] = '{8'h5A, 8'h5A, 4, 0};
      tbl[5] = '{8'h27, 8'h9C, 3, 1};
`else
      tbl[0] = '{8'hB4, 8'hB4, 4, 0};
      tbl[1] = '{8'h0D, 8'h0D, 4, 0};
      tbl[2] = '{8'h00, 8'h00, 4, 0};
      tbl[3] = '{8'hFF, 8'hFF, 4, 0};
      tbl[4] = '{8'h5A, 8'h5A, 4, 0};
      tbl[5] = '{8'h27, 8'h27, 4, 0};
`endif

      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pin8 = 8'($urandom);
         load8 = 1'($urandom);
         dready8 = 1'($urandom);
         pin48 = {16'($urandom), 32'($urandom)};
         load48 = 1'($urandom);
         dready48 = 1'($urandom);
         step();
         chk("rst busy8", busy8, 1'b0);
         chk("rst dvalid8", dvalid8, 1'b0);
         chk("rst last8", last8, 1'b0);
         chk("rst dout8", dout8, 2'b00);
         chk("rst skip8", skip8, 3'd0);
         chk("rst busy48/dvalid48", {busy48, dvalid48, last48, dout48}, 5'd0);
      end
      load8 = 1'b0;
      load48 = 1'b0;
      dready8 = 1'b1;
      dready48 = 1'b1;
      RST = 1'b1;
      step();

      for (int v = 0; v < 6; v++) begin
         pin8 = tbl[v].pin;
         load8 = 1'b1;
         dready8 = 1'b1;
         step();
         load8 = 1'b0;
         chk("busy8 after load", busy8, 1'b1);
         wait_valid8("first dvalid8 latency", exp_lat(tbl[v].skip));
         drain8(tbl[v].dig, tbl[v].ndig);
         chk("skip8", skip8, tbl[v].skip);
      end

      // Backpressure: first digit must hold for three stalled cycles.
      pin8 = 8'hB4;
      load8 = 1'b1;
      dready8 = 1'b0;
      step();
      load8 = 1'b0;
      wait_valid8("bp latency", exp_lat(0));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp dvalid8 hold", dvalid8, 1'b1);
         chk("bp dout8 hold", dout8, 2'b10);
         chk("bp last8 hold", last8, 1'b0);
      end
      drain8(8'hB4, 4);

      // LOAD held high through a word: ignored until BUSY drops.
      pin8 = 8'hB4;
      load8 = 1'b1;
      dready8 = 1'b1;
      step();
      pin8 = 8'hFF;
      wait_valid8("busy-load latency", exp_lat(0));
      drain8(8'hB4, 4);
      step();
      load8 = 1'b0;
      chk("second load accepted", busy8, 1'b1);
      wait_valid8("second word latency", exp_lat(0));
      drain8(8'hFF, 4);

      // Reset mid-word.
      pin8 = 8'hB4;
      load8 = 1'b1;
      dready8 = 1'b1;
      step();
      load8 = 1'b0;
      wait_valid8("midrst latency", exp_lat(0));
      step();
      chk("midrst in flight", dvalid8, 1'b1);
      RST = 1'b0;
      #1;
      chk("midrst busy8", busy8, 1'b0);
      chk("midrst dvalid8", dvalid8, 1'b0);
      chk("midrst dout8", dout8, 2'b00);
      chk("midrst last8", last8, 1'b0);
      step();
      RST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post-rst no digit", {busy8, dvalid8}, 2'b00);
      end

      run48(48'h9ABC_DEF0_1234);
      run48(48'hF0F0_1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
